sample_packet_parser: RTL and testbench
=======================================

// Module: sample_packet_parser
// PURPOSE
//  Consumes 32-bit words from the serial-in/parallel-out receive register (one-cycle
//  word_valid strobes) and parses them into packets: header, LENGTH payload words,
//  optional checksum trailer. Payload words are tagged with command and channel.
//  They are buffered in a small FIFO and handed to the synth core over a valid/ready
//  handshake. The upstream shift register cannot be stalled, so the FIFO absorbs
//  short downstream stalls.
// PARAMETERS
//  FIFO_DEPTH  4   payload FIFO entries; power of two, >= 2
//  MAGIC       8'hA5  required header byte [31:24]
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rstn         in   1   synchronous active-low reset
//  word_in      in   32  word from receive shift register
//  word_valid   in   1   word_in valid this cycle (single-cycle strobe, no backpressure)
//  sync_clear   in   1   abort current packet (upstream frame abort)
//  out_data     out  32  payload word at FIFO head
//  out_cmd      out  8   command byte of that word's packet
//  out_channel  out  8   channel byte of that word's packet
//  out_last     out  1   word is the final payload word of its packet
//  out_valid    out  1   FIFO non-empty
//  out_ready    in   1   consumer accepts the head word when out_valid && out_ready
//  packet_done  out  1   1-cycle pulse: packet fully parsed
//  err_header   out  1   1-cycle pulse: header magic mismatch
//  err_overflow out  1   1-cycle pulse: payload word dropped, FIFO full
//  err_checksum out  1   1-cycle pulse: trailer mismatch (0 when feature is off)
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty. All outputs are 0 (out_data/cmd/channel/last included).
//  Header: magic [31:24], cmd [23:16], channel [15:8], length [7:0] (payload words, 0..255).
//  FSM: IDLE -> PAYLOAD when a header has good magic and length>0. Latch cmd/channel,
//   load remaining = length.
//   - Bad magic in IDLE: stay in IDLE, pulse err_header next cycle, word discarded.
//   - length==0: with CHECKSUM_EN go to TRAILER (expected value 0). Without it, pulse
//     packet_done and stay in IDLE.
//   - PAYLOAD: each word_valid pushes {cmd,channel,last,word} and decrements remaining.
//     last=1 when remaining==1. Last word -> TRAILER (macro on) or IDLE + packet_done.
//   - TRAILER: next word_valid is compared, then -> IDLE and packet_done pulses;
//     on mismatch err_checksum pulses in the same cycle as packet_done.
//  Pulse timing: error and packet_done pulses are registered. They assert on the cycle
//   after the triggering word_valid.
//  Latency: payload word strobed at cycle N with FIFO empty -> out_valid=1 at N+1.
//  FIFO: out_* show the head entry (registered). A pop happens on out_valid&&out_ready.
//   - Push while full with no pop that cycle: word dropped, err_overflow pulses.
//     remaining still decrements, so framing is preserved.
//   - Push while full with a simultaneous pop: push accepted, no error.
//   - Push and pop on a 1-entry FIFO: head advances to the new word, out_valid stays 1.
//  sync_clear (any state): next state IDLE, remaining cleared, checksum accumulator
//   cleared. No packet_done. The FIFO contents and pop are unaffected.
//   sync_clear has priority over a same-cycle word_valid, and that word is discarded.
//  Reset mid-packet: everything returns to reset values, and the FIFO is emptied.
//  remaining is 8 bits; with length=255 it never wraps below 0.
// CONFIGURATION
//  PACKET_CHECKSUM_EN defined: the accumulator XORs all payload words of the packet
//   (including dropped ones) and the TRAILER state exists. The trailer word is
//   consumed and never pushed.
//  Undefined: no TRAILER state and no accumulator. err_checksum is tied to 0, and the
//   word after the last payload word is parsed as a header.
// TESTING
//  1 Reset, header A5_03_02_02, words 11,22 with out_ready=1 -> two outputs, cmd=03,
//    ch=02, last=0 then 1; packet_done pulses once.
//  2 Header 5A_xx_xx_01 -> err_header 1 pulse; the following valid header parses normally.
//  3 FIFO_DEPTH=4, out_ready=0, length=6 -> first 4 words buffered, 2 err_overflow pulses;
//    the next header is accepted.
//  4 length=3, sync_clear after word 2 -> FSM IDLE, no packet_done. The 2 buffered
//    words still drain, and the next header parses.
//  5 PACKET_CHECKSUM_EN: payload 0F,F0 with trailer FF -> no error. Trailer 00 ->
//    err_checksum and packet_done in the same cycle.
//  6 Header length=0 -> packet_done only, out_valid stays 0 (macro off). With the
//    macro on, trailer 0 is required.

Source files
------------

// File: rtl/sample_packet_parser_if.sv
// Handshake bundle for sample_packet_parser. The master side is the word source
// and payload consumer; the slave side is the parser.
interface sample_packet_parser_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        sync_clear;
    logic [31:0] out_data;
    logic [7:0]  out_cmd;
    logic [7:0]  out_channel;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        packet_done;
    logic        err_header;
    logic        err_overflow;
    logic        err_checksum;
    logic [1:0]  state_dbg;

    // out_valid/out_ready: the head word transfers on every posedge where both are 1;
    // out_valid never depends on out_ready, and the head is held stable until taken.
    modport master (
        output word_in, word_valid, sync_clear, out_ready,
        input  out_data, out_cmd, out_channel, out_last, out_valid,
        input  packet_done, err_header, err_overflow, err_checksum, state_dbg
    );

    modport slave (
        input  word_in, word_valid, sync_clear, out_ready,
        output out_data, out_cmd, out_channel, out_last, out_valid,
        output packet_done, err_header, err_overflow, err_checksum, state_dbg
    );
endinterface

// File: rtl/sample_packet_parser.sv
// Parses header/payload(/trailer) packets from a non-stallable word stream into a payload FIFO.
// Define PACKET_CHECKSUM_EN to enable the XOR checksum trailer word after each payload.
module sample_packet_parser #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input logic                   clk,
    input logic                   rstn,
    sample_packet_parser_if.slave bus
);
    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam int             EW      = 49;
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);

`ifdef PACKET_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, TRAILER = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1} state_t;
`endif

    state_t        state;
    logic [7:0]    cmd_q;
    logic [7:0]    chan_q;
    logic [7:0]    remaining;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          done_q;
    logic          err_hdr_q;
    logic          err_ovf_q;
`ifdef PACKET_CHECKSUM_EN
    logic [31:0]   csum;
    logic          err_csum_q;
`endif

    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic overflow;
    logic last_word;

    assign full      = (count == DEPTH_C);
    assign pop       = (count != '0) && bus.out_ready;
    assign push_req  = bus.word_valid && !bus.sync_clear && (state == PAYLOAD);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = push_req && (!full || pop);
    assign overflow  = push_req && full && !pop;
    assign last_word = (remaining == 8'd1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cmd_q     <= '0;
            chan_q    <= '0;
            remaining <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            done_q    <= 1'b0;
            err_hdr_q <= 1'b0;
            err_ovf_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
`ifdef PACKET_CHECKSUM_EN
            csum       <= '0;
            err_csum_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            err_hdr_q <= 1'b0;
            err_ovf_q <= overflow;
`ifdef PACKET_CHECKSUM_EN
            err_csum_q <= 1'b0;
`endif
            if (push) begin
                mem[wr_ptr] <= {cmd_q, chan_q, last_word, bus.word_in};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (bus.sync_clear) begin
                state     <= IDLE;
                remaining <= '0;
`ifdef PACKET_CHECKSUM_EN
                csum      <= '0;
`endif
            end else if (bus.word_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.word_in[31:24] != MAGIC) begin
                            err_hdr_q <= 1'b1;
                        end else if (bus.word_in[7:0] == 8'd0) begin
`ifdef PACKET_CHECKSUM_EN
                            state <= TRAILER;
                            csum  <= '0;
`else
                            done_q <= 1'b1;
`endif
                        end else begin
                            state     <= PAYLOAD;
                            cmd_q     <= bus.word_in[23:16];
                            chan_q    <= bus.word_in[15:8];
                            remaining <= bus.word_in[7:0];
`ifdef PACKET_CHECKSUM_EN
                            csum      <= '0;
`endif
                        end
                    end
                    PAYLOAD: begin
                        // Dropped words still count, keeping packet framing intact.
                        remaining <= remaining - 1'b1;
`ifdef PACKET_CHECKSUM_EN
                        csum <= csum ^ bus.word_in;
                        if (last_word) state <= TRAILER;
`else
                        if (last_word) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
`endif
                    end
`ifdef PACKET_CHECKSUM_EN
                    TRAILER: begin
                        state      <= IDLE;
                        done_q     <= 1'b1;
                        err_csum_q <= (bus.word_in != csum);
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign {bus.out_cmd, bus.out_channel, bus.out_last, bus.out_data} = mem[rd_ptr];
    assign bus.out_valid    = (count != '0);
    assign bus.packet_done  = done_q;
    assign bus.err_header   = err_hdr_q;
    assign bus.err_overflow = err_ovf_q;
    assign bus.state_dbg    = state;
`ifdef PACKET_CHECKSUM_EN
    assign bus.err_checksum = err_csum_q;
`else
    assign bus.err_checksum = 1'b0;
`endif
endmodule

// File: tb/tb_sample_packet_parser.sv
// Bench for sample_packet_parser: directed vector table, corner sequences and
// randomized traffic checked against a queue-based packet model.
module tb_sample_packet_parser;
    localparam int         DEPTH = 4;
    localparam logic [7:0] MAGIC = 8'hA5;
`ifdef PACKET_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sample_packet_parser_if bus();

    sample_packet_parser #(.FIFO_DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_ovf_seen  = 0;
    int n_done_seen = 0;

    // Reference model: packet phase (0 idle, 1 payload, 2 trailer) plus payload queue.
    logic [48:0] exp_q[$];
    int          m_phase;
    int          m_rem;
    logic [7:0]  m_cmd;
    logic [7:0]  m_ch;
    logic [31:0] m_csum;
    bit          e_done, e_errh, e_ovf, e_errc;

    typedef struct {
        logic [31:0] w;
        bit          v, clr, rdy;
        bit          e_valid;
        logic [31:0] e_data;
        logic [7:0]  e_cmd, e_ch;
        bit          e_last, e_done, e_errh;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_phase = 0; m_rem = 0; m_csum = '0; m_cmd = '0; m_ch = '0;
        e_done = 0; e_errh = 0; e_ovf = 0; e_errc = 0;
    endtask

    task automatic model_cycle(input logic [31:0] w, input bit v, input bit clr, input bit rdy);
        bit pop;
        bit do_push;
        logic [48:0] ent;
        pop = (exp_q.size() > 0) && rdy;
        do_push = 0;
        ent = '0;
        e_done = 0; e_errh = 0; e_ovf = 0; e_errc = 0;
        if (clr) begin
            m_phase = 0; m_rem = 0; m_csum = '0;
        end else if (v) begin
            if (m_phase == 0) begin
                if (w[31:24] != MAGIC) e_errh = 1;
                else if (w[7:0] == 8'd0) begin
                    if (CSUM) begin m_phase = 2; m_csum = '0; end
                    else e_done = 1;
                end else begin
                    m_phase = 1; m_rem = int'(w[7:0]);
                    m_cmd = w[23:16]; m_ch = w[15:8]; m_csum = '0;
                end
            end else if (m_phase == 1) begin
                ent = {m_cmd, m_ch, (m_rem == 1), w};
                if (exp_q.size() == DEPTH && !pop) e_ovf = 1;
                else do_push = 1;
                m_csum = m_csum ^ w;
                m_rem--;
                if (m_rem == 0) begin
                    if (CSUM) m_phase = 2;
                    else begin m_phase = 0; e_done = 1; end
                end
            end else begin
                e_done = 1;
                e_errc = (w != m_csum);
                m_phase = 0;
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(ent);
    endtask

    task automatic compare_outputs();
        check("out_valid", bus.out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0)
            check("head", {bus.out_cmd, bus.out_channel, bus.out_last, bus.out_data}, exp_q[0]);
        check("pulses", {bus.packet_done, bus.err_header, bus.err_overflow, bus.err_checksum},
              {e_done, e_errh, e_ovf, e_errc});
        check("state", bus.state_dbg, m_phase);
        if (bus.err_overflow) n_ovf_seen++;
        if (bus.packet_done) n_done_seen++;
    endtask

    task automatic step(input logic [31:0] w, input bit v, input bit clr, input bit rdy);
        bus.word_in = w; bus.word_valid = v; bus.sync_clear = clr; bus.out_ready = rdy;
        model_cycle(w, v, clr, rdy);
        @(posedge clk); #1;
        compare_outputs();
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        bus.word_in = '0; bus.word_valid = 0; bus.sync_clear = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_head", {bus.out_cmd, bus.out_channel, bus.out_last, bus.out_data}, 0);
        check("rst_pulses", {bus.packet_done, bus.err_header, bus.err_overflow, bus.err_checksum}, 0);
        check("rst_state", bus.state_dbg, 0);
        model_reset();
        rstn = 1'b1;
    endtask

    function automatic vec_t mk(logic [31:0] w, bit v, bit rdy, bit ev, logic [31:0] ed,
                                logic [7:0] ec, logic [7:0] ech, bit el, bit edn, bit eh);
        vec_t r;
        r.w = w; r.v = v; r.clr = 0; r.rdy = rdy; r.e_valid = ev; r.e_data = ed;
        r.e_cmd = ec; r.e_ch = ech; r.e_last = el; r.e_done = edn; r.e_errh = eh;
        return r;
    endfunction

    task automatic send(input logic [31:0] w, input bit rdy);
        step(w, 1'b1, 1'b0, rdy);
    endtask

    initial begin
        int base;
        logic [31:0] x;
        reset_dut();

        // Normal packet, then bad magic followed by a good header.
        vecs.push_back(mk(32'hA503_0202, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0011, 1, 1, 1, 32'h11, 8'h03, 8'h02, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0022, 1, 1, 1, 32'h22, 8'h03, 8'h02, 1, !CSUM, 0));
`ifdef PACKET_CHECKSUM_EN
        vecs.push_back(mk(32'h0000_0033, 1, 1, 0, 0, 0, 0, 0, 1, 0));
`endif
        vecs.push_back(mk(32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h5A00_0001, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(32'hA507_0901, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hDEAD_BEEF, 1, 1, 1, 32'hDEADBEEF, 8'h07, 8'h09, 1, !CSUM, 0));
`ifdef PACKET_CHECKSUM_EN
        vecs.push_back(mk(32'hDEAD_BEEF, 1, 1, 0, 0, 0, 0, 0, 1, 0));
`endif
        vecs.push_back(mk(32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].w, vecs[i].v, vecs[i].clr, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].e_valid);
            if (vecs[i].e_valid)
                check($sformatf("vec%0d_head", i),
                      {bus.out_cmd, bus.out_channel, bus.out_last, bus.out_data},
                      {vecs[i].e_cmd, vecs[i].e_ch, vecs[i].e_last, vecs[i].e_data});
            check($sformatf("vec%0d_done_errh", i), {bus.packet_done, bus.err_header},
                  {vecs[i].e_done, vecs[i].e_errh});
        end

        // Overflow: six words into a stalled four-entry FIFO.
        base = n_ovf_seen;
        send(32'hA510_2006, 0);
        x = '0;
        for (int i = 0; i < 6; i++) begin send(32'h100 + i, 0); x ^= 32'h100 + i; end
        if (CSUM) send(x, 0);
        check("t3_ovf_pulses", n_ovf_seen - base, 2);
        check("t3_still_valid", bus.out_valid, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        send(32'hA511_2201, 1);
        send(32'h0000_CAFE, 1);
        if (CSUM) send(32'h0000_CAFE, 1);
        step(0, 0, 0, 1);

        // sync_clear mid-packet, with a simultaneous word that must be dropped.
        base = n_done_seen;
        send(32'hA501_0203, 0);
        send(32'hA1, 0);
        send(32'hA2, 0);
        step(32'hA3, 1, 1, 0);
        check("t4_state_idle", bus.state_dbg, 0);
        check("t4_no_done", n_done_seen - base, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        send(32'hA505_0601, 1);
        send(32'h0000_00B1, 1);
        if (CSUM) send(32'h0000_00B1, 1);
        step(0, 0, 0, 1);

`ifdef PACKET_CHECKSUM_EN
        send(32'hA501_0102, 1); send(32'h0F, 1); send(32'hF0, 1); send(32'hFF, 1);
        check("t5_good_trailer", {bus.packet_done, bus.err_checksum}, 2'b10);
        send(32'hA501_0102, 1); send(32'h0F, 1); send(32'hF0, 1); send(32'h00, 1);
        check("t5_bad_trailer", {bus.packet_done, bus.err_checksum}, 2'b11);
        step(0, 0, 0, 1);
`endif

        // Zero-length packet.
        send(32'hA501_0100, 1);
`ifdef PACKET_CHECKSUM_EN
        check("t6_wait_trailer", bus.packet_done, 0);
        send(32'h0, 1);
`endif
        check("t6_done", bus.packet_done, 1);
        check("t6_no_output", bus.out_valid, 0);

        // Maximum length: remaining must count down to exactly one without wrapping.
        base = n_done_seen;
        send(32'hA502_03FF, 1);
        x = '0;
        for (int i = 0; i < 255; i++) begin send(32'h1000 + i, 1); x ^= 32'h1000 + i; end
        if (CSUM) send(x, 1);
        step(0, 0, 0, 1);
        check("len255_done_once", n_done_seen - base, 1);
        check("len255_idle", bus.state_dbg, 0);

        // Reset in the middle of a packet with buffered data.
        send(32'hA501_0103, 0);
        send(32'h77, 0);
        reset_dut();
        send(32'hA509_0801, 1);
        send(32'h88, 1);
        if (CSUM) send(32'h88, 1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit v, clr, rdy;
            logic [31:0] w;
            int r;
            rdy = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 49) == 0);
            v   = ($urandom_range(0, 9) < 7);
            r   = $urandom_range(0, 9);
            if (m_phase == 0) begin
                if (r == 0) w = $urandom();
                else w = {MAGIC, 8'($urandom()), 8'($urandom()),
                          (r == 1) ? 8'd0 : 8'($urandom_range(1, 6))};
            end else if (m_phase == 1) w = $urandom();
            else w = (r < 5) ? m_csum : $urandom();
            if ($urandom_range(0, 599) == 0) reset_dut();
            else step(w, v, clr, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
